tetris_cmd_seq: RTL and testbench

//  Upstream command sequencer for the tetris game engine. Turns one-cycle player button pulses and an internal

---
 rtl/tetris_cmd_seq.sv | 118 +++++++++++
 tb/tb_tetris_cmd_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_cmd_seq.sv
// tetris_cmd_seq: turns button pulses and a gravity timer into a one-at-a-time engine command stream
module tetris_cmd_seq #(
  parameter int          gravity_period_p = 50_000_000,
  parameter logic [15:0] lfsr_seed_p      = 16'hACE1,
  parameter int          spawn_x_p        = 6
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       left_i,
  input  logic       right_i,
  input  logic       rotate_i,
  input  logic       drop_i,
  output logic       op_v_o,
  input  logic       op_ready_i,
  output logic [2:0] op_o,
  output logic [2:0] tile_o,
  output logic [4:0] spawn_x_o,
  input  logic       resp_v_i,
  input  logic       resp_ok_i,
  output logic       game_over_o
);
  localparam logic [2:0] op_nop = 3'd0, op_new = 3'd1, op_move_left = 3'd2, op_move_right = 3'd3;
  localparam logic [2:0] op_move_down = 3'd4, op_rotate = 3'd5, op_commit = 3'd6, op_check = 3'd7;
  localparam logic [2:0] tile_non = 3'd0, tile_t = 3'd6;
  localparam int gw = $clog2(gravity_period_p);
  typedef enum logic [2:0] {s_idle, s_run, s_issue, s_wait, s_commit, s_check, s_spawn, s_over} state_t;
  state_t state;
  logic [15:0] lfsr;
  logic [gw-1:0] gcnt;
  logic pend_l, pend_r, pend_rot, pend_g, drop_m;
  logic active, g_hit, xfer;
  logic [2:0] pick, new_tile;
  always_comb begin
    active = state != s_idle && state != s_over;
    g_hit = gcnt == gw'(gravity_period_p - 1);
    xfer = op_v_o && op_ready_i;
    new_tile = lfsr[2:0] == 3'd0 ? tile_t : lfsr[2:0];
    pick = (drop_m || pend_g) ? op_move_down : pend_rot ? op_rotate :
           pend_l ? op_move_left : pend_r ? op_move_right : op_nop;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= s_idle;
      op_v_o <= 1'b0;
      op_o <= op_nop;
      tile_o <= tile_non;
      spawn_x_o <= '0;
      game_over_o <= 1'b0;
      {pend_l, pend_r, pend_rot, pend_g, drop_m} <= '0;
      gcnt <= '0;
      lfsr <= lfsr_seed_p;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (active) gcnt <= g_hit ? '0 : gcnt + 1'b1;
      case (state)
        s_idle, s_over: if (start_i) begin
          state <= s_spawn;
          op_v_o <= 1'b1;
          op_o <= op_new;
          tile_o <= new_tile;
          spawn_x_o <= 5'(spawn_x_p);
          game_over_o <= 1'b0;
          {pend_l, pend_r, pend_rot, pend_g, drop_m} <= '0;
        end
        s_run: if (pick != op_nop) begin
          state <= s_issue;
          op_v_o <= 1'b1;
          op_o <= pick;
          tile_o <= tile_non;
          spawn_x_o <= '0;
        end
        s_wait: if (resp_v_i) begin
          if (op_o == op_new) begin
            if (resp_ok_i) begin
              state <= s_run;
              gcnt <= '0;
            end else begin
              state <= s_over;
              game_over_o <= 1'b1;
            end
          end else if (op_o == op_move_down && !resp_ok_i) begin
            state <= s_commit;
            op_v_o <= 1'b1;
            op_o <= op_commit;
            drop_m <= 1'b0;
          end else if (op_o == op_commit) begin
            state <= s_check;
            op_v_o <= 1'b1;
            op_o <= op_check;
          end else if (op_o == op_check) begin
            state <= s_spawn;
            op_v_o <= 1'b1;
            op_o <= op_new;
            tile_o <= new_tile;
            spawn_x_o <= 5'(spawn_x_p);
          end else state <= s_run;
        end
        default: if (xfer) begin
          state <= s_wait;
          op_v_o <= 1'b0;
          if (op_o == op_move_down) pend_g <= 1'b0;
          if (op_o == op_rotate) pend_rot <= 1'b0;
          if (op_o == op_move_left) pend_l <= 1'b0;
          if (op_o == op_move_right) pend_r <= 1'b0;
        end
      endcase
      // new pulses win over a same-cycle service clear so none is lost
      if (active) begin
        if (left_i) pend_l <= 1'b1;
        if (right_i) pend_r <= 1'b1;
        if (rotate_i) pend_rot <= 1'b1;
        if (drop_i) drop_m <= 1'b1;
        if (g_hit) pend_g <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tetris_cmd_seq.sv
// tb_tetris_cmd_seq: directed bench with an automatic engine responder and a transfer log
module tb_tetris_cmd_seq;
  localparam int op_nop = 0, op_new = 1, op_left = 2, op_right = 3, op_down = 4, op_rot = 5, op_commit = 6, op_check = 7;
  logic clk = 0, rst = 1, start = 0, left = 0, right = 0, rotate = 0, drop = 0, op_ready = 1;
  logic resp_v = 0, resp_ok = 0, hold = 0, ok_new = 1, ok_down = 1;
  logic op_v, game_over;
  logic [2:0] op, tile;
  logic [4:0] spawn_x;
  int cyc = 0, n_req = 0, n_done = 0, rd = 0, errs = 0, checks = 0;
  int x_op[4096], x_tile[4096], x_sx[4096], x_cyc[4096];
  bit ok_arr[4096];
  tetris_cmd_seq #(.gravity_period_p(8)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .left_i(left), .right_i(right),
    .rotate_i(rotate), .drop_i(drop), .op_v_o(op_v), .op_ready_i(op_ready), .op_o(op),
    .tile_o(tile), .spawn_x_o(spawn_x), .resp_v_i(resp_v), .resp_ok_i(resp_ok),
    .game_over_o(game_over));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst && op_v && op_ready && n_req < 4096) begin
      x_op[n_req] = int'(op);
      x_tile[n_req] = int'(tile);
      x_sx[n_req] = int'(spawn_x);
      x_cyc[n_req] = cyc;
      ok_arr[n_req] = int'(op) == op_new ? ok_new : int'(op) == op_down ? ok_down : 1'b1;
      n_req++;
    end
  always @(posedge clk) begin
    #1;
    if (n_done != n_req && !hold) begin
      resp_ok = ok_arr[n_done];
      resp_v = 1;
      n_done++;
    end else begin
      resp_v = 0;
      resp_ok = 0;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic [4:0] m);
    {start, left, right, rotate, drop} = m;
    tick(1);
    {start, left, right, rotate, drop} = '0;
  endtask
  task automatic next_xfer(output int o, output int t, output int s, output int c);
    int w = 0;
    while (rd >= n_req && w < 300) begin
      tick(1);
      w++;
    end
    if (rd >= n_req) begin
      chk("xfer_timeout", 1, 0);
      o = -1; t = -1; s = -1; c = 0;
    end else begin
      o = x_op[rd]; t = x_tile[rd]; s = x_sx[rd]; c = x_cyc[rd];
      rd++;
    end
  endtask
  task automatic next_nondown(output int o);
    int t, s, c, k = 0;
    do begin
      next_xfer(o, t, s, c);
      k++;
    end while (o == op_down && k < 20);
  endtask
  initial begin
    int o, t, s, c, c0, c1, n, bad;
    tick(3);
    chk("rst_op_v", op_v, 0);
    chk("rst_op", op, op_nop);
    chk("rst_tile", tile, 0);
    chk("rst_spawn_x", spawn_x, 0);
    chk("rst_game_over", game_over, 0);
    rst = 0;
    tick(2);
    pulse(5'b01000);
    tick(3);
    chk("idle_ignores_left", op_v, 0);
    pulse(5'b10000);
    next_xfer(o, t, s, c0);
    chk("first_op_new", o, op_new);
    chk("first_tile_nonzero", t != 0, 1);
    chk("first_spawn_x", s, 6);
    chk("first_game_over", game_over, 0);
    next_xfer(o, t, s, c);
    chk("grav_first_op", o, op_down);
    chk("grav_first_gap", c - c0, 11);
    chk("grav_down_tile", t, 0);
    for (int i = 0; i < 3; i++) begin
      c1 = c;
      next_xfer(o, t, s, c);
      chk("grav_op", o, op_down);
      chk("grav_gap", c - c1, 8);
    end
    tick(3);
    hold = 1;
    next_xfer(o, t, s, c);
    pulse(5'b01000);
    tick(1);
    pulse(5'b01000);
    hold = 0;
    next_nondown(o);
    chk("coalesce_left", o, op_left);
    tick(30);
    n = 0;
    while (rd < n_req) begin
      if (x_op[rd] == op_left) n++;
      rd++;
    end
    chk("coalesce_no_extra", n, 0);
    tick(3);
    hold = 1;
    next_xfer(o, t, s, c);
    pulse(5'b01010);
    hold = 0;
    next_nondown(o);
    chk("prio_rotate_first", o, op_rot);
    next_nondown(o);
    chk("prio_left_second", o, op_left);
    tick(3);
    ok_down = 0;
    ok_new = 0;
    rd = n_req;
    next_nondown(o);
    ok_down = 1;
    chk("fail_commit", o, op_commit);
    next_xfer(o, t, s, c);
    chk("fail_check", o, op_check);
    next_xfer(o, t, s, c);
    ok_new = 1;
    chk("fail_new", o, op_new);
    chk("respawn_spawn_x", s, 6);
    tick(3);
    chk("over_flag", game_over, 1);
    pulse(5'b00001);
    n = 0;
    repeat (100) begin
      tick(1);
      if (op_v) n++;
    end
    chk("over_quiet", n, 0);
    chk("over_flag_held", game_over, 1);
    pulse(5'b10000);
    next_xfer(o, t, s, c);
    chk("restart_new", o, op_new);
    chk("restart_flag_clear", game_over, 0);
    next_xfer(o, t, s, c);
    next_xfer(o, t, s, c1);
    next_xfer(o, t, s, c);
    chk("restart_no_drop", c - c1, 8);
    tick(3);
    op_ready = 0;
    pulse(5'b00001);
    n = 0;
    while (!op_v && n < 30) begin
      tick(1);
      n++;
    end
    chk("stall_v", op_v, 1);
    bad = 0;
    repeat (10) begin
      if (!(op_v && int'(op) == op_down && tile == 0 && spawn_x == 0)) bad++;
      tick(1);
    end
    chk("stall_stable", bad, 0);
    op_ready = 1;
    next_xfer(o, t, s, c1);
    chk("drop_op0", o, op_down);
    next_xfer(o, t, s, c);
    chk("drop_op1", o, op_down);
    chk("drop_gap1", c - c1, 3);
    c1 = c;
    next_xfer(o, t, s, c);
    chk("drop_gap2", c - c1, 3);
    ok_down = 0;
    rd = n_req;
    next_nondown(o);
    ok_down = 1;
    chk("drop_end_commit", o, op_commit);
    next_xfer(o, t, s, c);
    chk("drop_end_check", o, op_check);
    next_xfer(o, t, s, c);
    chk("drop_end_new", o, op_new);
    next_xfer(o, t, s, c);
    next_xfer(o, t, s, c1);
    next_xfer(o, t, s, c);
    chk("drop_cleared_gap", c - c1, 8);
    tick(3);
    op_ready = 0;
    n = 0;
    while (!op_v && n < 30) begin
      tick(1);
      n++;
    end
    rst = 1;
    tick(1);
    chk("rst_mid_hs_v", op_v, 0);
    chk("rst_mid_hs_op", op, op_nop);
    rst = 0;
    op_ready = 1;
    tick(3);
    hold = 1;
    rd = n_req;
    pulse(5'b10000);
    next_xfer(o, t, s, c);
    chk("held_new", o, op_new);
    rst = 1;
    tick(2);
    rst = 0;
    hold = 0;
    n = 0;
    repeat (6) begin
      tick(1);
      if (op_v || game_over) n++;
    end
    chk("stale_resp_ignored", n, 0);
    rd = n_req;
    pulse(5'b10000);
    next_xfer(o, t, s, c);
    chk("after_rst_new", o, op_new);
    tick(5);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
